fp_mul_arbiter: RTL

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin front end that shares one two-stage
// single-precision multiplier between two requesters. Only one operation
// is in flight at a time. Each requester has its own response slot, which
// stays valid until that requester pops it.
//
// state | meaning
// IDLE  | waiting for an eligible requester; ready may be asserted
// EXEC1 | multiplier stage 1 active, operands held
// EXEC2 | multiplier stage 2 active, sign/rounding mode sampled, operands held
// WB    | multiplier result valid; captured into owner's slot on exit
module fp_mul_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_rm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_rm,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic [3:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [3:0]  rsp1_flags,
  output logic        mul_act,
  output logic [31:0] mul_in1,
  output logic [31:0] mul_in2,
  output logic [2:0]  mul_round_m,
  input  logic [31:0] mul_out,
  input  logic        mul_ov,
  input  logic        mul_un,
  input  logic        mul_done,
  input  logic        mul_inv,
  input  logic        mul_inexact,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] rsp_ready;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [31:0]      rsp_data_q  [N_REQ];
  logic [3:0]       rsp_flags_q [N_REQ];
  logic             last_grant_q;
  logic             owner_q;
  logic             grant_id;
  logic             any_grant;
  logic             accept;
  logic             wb_done;
  logic [15:0]      op_count_q;
  logic             mul_err_q;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  // A requester with an unread response cannot issue again.
  assign eligible  = req_valid & ~rsp_valid_q;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_id  = 1'b0;
    any_grant = 1'b0;
    if (eligible[0] && eligible[1]) begin
      grant_id  = ~last_grant_q;
      any_grant = 1'b1;
    end else if (eligible[0]) begin
      grant_id  = 1'b0;
      any_grant = 1'b1;
    end else if (eligible[1]) begin
      grant_id  = 1'b1;
      any_grant = 1'b1;
    end
  end

  // rst gates ready so it reads 0 while reset is held, even though IDLE.
  assign accept     = (state_q == S_IDLE) && any_grant && rst;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign wb_done    = (state_q == S_WB);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and multiplier enable; the pipeline advances unconditionally.
  always_comb begin
    state_d = state_q;
    mul_act = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC1;
      S_EXEC1: begin
        mul_act = 1'b1;
        state_d = S_EXEC2;
      end
      S_EXEC2: begin
        mul_act = 1'b1;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on acceptance only, so operands stay put until the next issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_in1      <= '0;
      mul_in2      <= '0;
      mul_round_m  <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      owner_q      <= grant_id;
      last_grant_q <= grant_id;
      if (grant_id) begin
        mul_in1     <= req1_a;
        mul_in2     <= req1_b;
        mul_round_m <= req1_rm;
      end else begin
        mul_in1     <= req0_a;
        mul_in2     <= req0_b;
        mul_round_m <= req0_rm;
      end
    end
  end

  // Response slots: load on WB exit for the owner, clear on pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        rsp_data_q[k]  <= '0;
        rsp_flags_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (wb_done && (owner_q == 1'(k))) begin
          rsp_valid_q[k] <= 1'b1;
          rsp_data_q[k]  <= mul_out;
          rsp_flags_q[k] <= {mul_inv, mul_ov, mul_un, mul_inexact};
        end else if (rsp_valid_q[k] && rsp_ready[k]) begin
          rsp_valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // Completion counter (wraps) and sticky flag for a result that was not ready in WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count_q <= '0;
      mul_err_q  <= 1'b0;
    end else if (wb_done) begin
      op_count_q <= op_count_q + 16'd1;
      if (!mul_done) mul_err_q <= 1'b1;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp0_flags = rsp_flags_q[0];
  assign rsp1_flags = rsp_flags_q[1];
  assign op_count   = op_count_q;

endmodule
